// File: rtl/regport_pkg.sv
// Shared constants and types for the register-file read-port arbiter.
package regport_pkg;

  localparam int unsigned NUM_REGS     = 32;
  localparam int unsigned ZERO_REG_IDX = 31;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [63:0] reg_word_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regport_arbiter_rr_pick.sv
// Rotate-priority picker: first set request at or after ptr_i, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((32'(ptr_i) + i) % N);
      if (!found && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regport_arbiter.sv
// Round-robin arbiter sharing one register-file read port between NUM_REQ
// requesters; read data returns one cycle after the grant on a valid/ready channel.
module regport_arbiter
  import regport_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 64,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         rd_sel,
  input  logic [DATA_W-1:0]         rd_data,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  input  logic [NUM_REQ-1:0]        resp_ready
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  owner_q, owner_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic [ADDR_W-1:0]   rd_sel_q, rd_sel_d;

  logic                owner_ack;
  logic                can_grant;
  logic [NUM_REQ-1:0]  pick_req;
  logic [NUM_REQ-1:0]  gnt_oh;
  logic [PTR_W-1:0]    gnt_idx;
  logic                gnt_any;
  logic [ADDR_W-1:0]   gnt_addr;

  // Reset suppresses grants so nothing is handshaken in a reset cycle.
  assign owner_ack = |(resp_ready & owner_q);
  assign can_grant = !reset && ((state_q == ST_IDLE) || owner_ack);
  assign pick_req  = can_grant ? req_valid : '0;
  assign gnt_any   = |gnt_oh;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (PTR_W)
  ) u_pick (
    .req_i (pick_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt_oh),
    .idx_o (gnt_idx)
  );

  always_comb begin
    gnt_addr = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt_oh[k]) gnt_addr = req_addr[k*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (gnt_any) state_d = ST_BUSY;
      ST_BUSY: if (!gnt_any && owner_ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = gnt_oh;
    rd_sel      = gnt_any ? gnt_addr : rd_sel_q;
    resp_valid  = (state_q == ST_BUSY) ? owner_q : '0;
    resp_data   = resp_data_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    resp_data_d = resp_data_q;
    rd_sel_d    = rd_sel_q;
    if (gnt_any) begin
      owner_d     = gnt_oh;
      rr_ptr_d    = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      resp_data_d = (ZERO_REG && (gnt_addr == ADDR_W'(ZERO_REG_IDX))) ? '0 : rd_data;
      rd_sel_d    = gnt_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      resp_data_q <= '0;
      rd_sel_q    <= '0;
    end else begin
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      resp_data_q <= resp_data_d;
      rd_sel_q    <= rd_sel_d;
    end
  end

endmodule

// File: tb/tb_regport_arbiter.sv
// Directed bench for regport_arbiter with a regfile/read-mux model; a second
// instance with ZERO_REG=0 covers the non-XZR read of index 31.
module tb_regport_arbiter;
  import regport_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR-1:0]     resp_ready;
  logic [NR-1:0]     req_ready0, resp_valid0, req_ready1, resp_valid1;
  reg_idx_t          rd_sel0, rd_sel1;
  reg_word_t         rd_data0, rd_data1, resp_data0, resp_data1;
  reg_word_t         regs [NUM_REGS];
  reg_word_t         rr_exp [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rd_data0 = regs[rd_sel0];
  assign rd_data1 = regs[rd_sel1];

  regport_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(64), .ZERO_REG(1'b1)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready0), .rd_sel(rd_sel0), .rd_data(rd_data0),
    .resp_valid(resp_valid0), .resp_data(resp_data0), .resp_ready(resp_ready)
  );

  regport_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(64), .ZERO_REG(1'b0)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready1), .rd_sel(rd_sel1), .rd_data(rd_data1),
    .resp_valid(resp_valid1), .resp_data(resp_data1), .resp_ready(resp_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int k, input logic [AW-1:0] a);
    req_addr[k*AW +: AW] = a;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 64'(i) * 64'h100 + 64'h11;
    regs[5]  = 64'h2803;
    regs[14] = 64'h0E0E;
    regs[31] = 64'h010F;
    rr_exp = '{64'h111, 64'h211, 64'h311, 64'h411};

    reset = 1'b1; req_valid = '0; req_addr = '0; resp_ready = '0;
    step(); step();
    chk("rst_req_ready", 64'(req_ready0), 64'h0);
    chk("rst_resp_valid", 64'(resp_valid0), 64'h0);
    chk("rst_resp_data", resp_data0, 64'h0);
    chk("rst_rd_sel", 64'(rd_sel0), 64'h0);
    reset = 1'b0;

    // Single read
    req_valid = 4'b0001; set_addr(0, 5'd5);
    #1;
    chk("single_req_ready", 64'(req_ready0), 64'b0001);
    chk("single_rd_sel", 64'(rd_sel0), 64'd5);
    step();
    chk("single_resp_valid", 64'(resp_valid0), 64'b0001);
    chk("single_resp_data", resp_data0, 64'h2803);
    req_valid = '0; resp_ready = 4'hF;
    step();
    chk("single_consumed", 64'(resp_valid0), 64'h0);
    chk("single_rd_sel_hold", 64'(rd_sel0), 64'd5);

    // Round-robin, all valid, always accepted
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_valid = 4'hF;
    for (int k = 0; k < 4; k++) set_addr(k, AW'(k + 1));
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("rr_req_ready", 64'(req_ready0), 64'(4'b0001 << (c % 4)));
      step();
      chk("rr_resp_valid", 64'(resp_valid0), 64'(4'b0001 << (c % 4)));
      chk("rr_resp_data", resp_data0, rr_exp[c % 4]);
    end

    // Backpressure on requester 2
    req_valid = 4'b0100; set_addr(2, 5'd14);
    #1;
    chk("bp_grant2", 64'(req_ready0), 64'b0100);
    step();
    chk("bp_resp_valid", 64'(resp_valid0), 64'b0100);
    chk("bp_resp_data", resp_data0, 64'h0E0E);
    resp_ready = 4'b1011; req_valid = 4'b1011;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_stall_ready", 64'(req_ready0), 64'h0);
      chk("bp_stall_valid", 64'(resp_valid0), 64'b0100);
      chk("bp_stall_data", resp_data0, 64'h0E0E);
      chk("bp_stall_rd_sel", 64'(rd_sel0), 64'd14);
      step();
    end
    resp_ready = 4'hF;
    #1;
    chk("bp_release_grant3", 64'(req_ready0), 64'b1000);
    chk("bp_release_rd_sel", 64'(rd_sel0), 64'd4);
    step();
    chk("bp_release_valid", 64'(resp_valid0), 64'b1000);
    chk("bp_release_data", resp_data0, 64'h411);

    // Zero register
    req_valid = '0;
    step();
    chk("zr_idle", 64'(resp_valid0), 64'h0);
    req_valid = 4'b0010; set_addr(1, 5'd31);
    #1;
    chk("zr_grant1", 64'(req_ready0), 64'b0010);
    step();
    chk("zr_on_data", resp_data0, 64'h0);
    chk("zr_off_data", resp_data1, 64'h010F);
    chk("zr_off_valid", 64'(resp_valid1), 64'b0010);

    // Pointer wrap and idle hold
    req_valid = 4'b1000; set_addr(3, 5'd7);
    #1;
    chk("wrap_grant3", 64'(req_ready0), 64'b1000);
    step();
    chk("wrap_data3", resp_data0, 64'h711);
    req_valid = 4'b0001; set_addr(0, 5'd9);
    #1;
    chk("wrap_grant0", 64'(req_ready0), 64'b0001);
    step();
    chk("wrap_data0", resp_data0, 64'h911);
    req_valid = 4'b1001;
    #1;
    chk("wrap_prio3", 64'(req_ready0), 64'b1000);
    step();
    chk("wrap_prio_valid", 64'(resp_valid0), 64'b1000);
    chk("wrap_prio_data", resp_data0, 64'h711);
    req_valid = '0;
    #1;
    chk("idle_rd_sel_hold", 64'(rd_sel0), 64'd7);
    step();
    chk("idle_resp_valid", 64'(resp_valid0), 64'h0);
    chk("idle_rd_sel_hold2", 64'(rd_sel0), 64'd7);

    // Reset while BUSY and stalled
    req_valid = 4'b0100; set_addr(2, 5'd2); resp_ready = '0;
    #1;
    chk("mrst_grant2", 64'(req_ready0), 64'b0100);
    step();
    chk("mrst_busy_valid", 64'(resp_valid0), 64'b0100);
    chk("mrst_busy_data", resp_data0, 64'h211);
    req_valid = 4'hF; reset = 1'b1;
    #1;
    chk("mrst_no_grant", 64'(req_ready0), 64'h0);
    step();
    chk("mrst_resp_valid", 64'(resp_valid0), 64'h0);
    chk("mrst_resp_data", resp_data0, 64'h0);
    chk("mrst_rd_sel", 64'(rd_sel0), 64'h0);
    reset = 1'b0;
    #1;
    chk("mrst_first_grant", 64'(req_ready0), 64'b0001);
    step();
    chk("mrst_first_valid", 64'(resp_valid0), 64'b0001);
    chk("mrst_first_data", resp_data0, 64'h911);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regport_arbiter.md
Name: regport_arbiter

Overview:
- Round-robin arbiter that shares one 32-entry x 64-bit register-file read port between NUM_REQ requesters, for example decode operand fetch, a debug dump unit and a trace unit.
- Drives the 5-bit select of the shared 32:1 read mux and samples its combinational output.
- Returns the read data to the granted requester one cycle later over a valid/ready response channel.
- Sits between the requesters and the register-file read mux in the processor datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 5, register index width.
- DATA_W, 64, register width.
- ZERO_REG, 1, when 1 a read of index 31 returns 0 regardless of rd_data (XZR semantics).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester read request.
- req_addr  input  NUM_REQ x ADDR_W  per-requester register index.
- req_ready  output  NUM_REQ  one-hot grant; handshake = req_valid[k] & req_ready[k].
- rd_sel  output  ADDR_W  select to the shared read mux.
- rd_data  input  DATA_W  shared read mux output (combinational from rd_sel).
- resp_valid  output  NUM_REQ  one-hot: response present for requester k.
- resp_data  output  DATA_W  response data, shared by all requesters.
- resp_ready  input  NUM_REQ  per-requester response accept.

Behaviour:
- Reset values:
  - req_ready = 0, resp_valid = 0, resp_data = 0, rd_sel = 0.
  - rr_ptr = 0, state = IDLE.
- Reset asserted mid-transaction discards any buffered response with no resp_valid pulse; it wins over every other event in that cycle.
- States:
  - IDLE: no response buffered.
  - BUSY: response buffered in resp_data; its owner is held in a one-hot owner register.
- can_grant = (state==IDLE) | resp_ready[owner].
- Arbitration (combinational, cycle T):
  - If can_grant, search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first valid requester g gets req_ready[g]=1; all other req_ready bits are 0.
  - If no request is valid or can_grant=0, all req_ready are 0.
- rd_sel = req_addr[g] while a grant is active; otherwise rd_sel holds its last registered value (no glitching to 0).
- On a handshake at the end of cycle T:
  - resp_data <= (ZERO_REG && req_addr[g]==31) ? 0 : rd_data.
  - owner <= g; state <= BUSY; rr_ptr <= (g+1) mod NUM_REQ.
  - resp_valid[g]=1 from cycle T+1, so latency is 1 cycle.
- Response consumption:
  - In BUSY with resp_ready[owner]=1 and no new grant: state <= IDLE and resp_valid clears the next cycle.
  - In BUSY with resp_ready[owner]=1 and a new grant in the same cycle: the response is replaced back-to-back, giving throughput of 1 read per cycle.
- In BUSY with resp_ready[owner]=0:
  - resp_valid and resp_data are held stable.
  - No grants are issued and rr_ptr is frozen.
- resp_ready bits of non-owners are ignored.
- rr_ptr only advances on a handshake, so a requester that drops req_valid loses no priority.
- A requester may change req_addr while not granted. req_addr is sampled only in the handshake cycle.
- Starvation-free: with all NUM_REQ requesters continuously valid and responses always accepted, each is granted exactly once per NUM_REQ cycles.

Decomposition:
- Package regport_pkg holds:
  - constants NUM_REGS=32 and ZERO_REG_IDX=31;
  - typedef reg_idx_t (logic [4:0]);
  - typedef reg_word_t (logic [63:0]).
- One sub-module, rr_pick: combinational rotate-priority picker. Inputs are the req vector and rr_ptr; outputs are the one-hot grant and its binary index. Reusable by other arbiters in the design.
- The read mux itself is instantiated outside this block; the bench instantiates the existing 32:1 mux and regfile model.

Test Plan:
- Single read: reset, then req_valid=0001 with req_addr[0]=5 and reg5=0x2803 -> req_ready=0001 in T; resp_valid=0001 and resp_data=0x2803 in T+1.
- Round-robin: all four requesters valid continuously (addrs 1,2,3,4), resp_ready=1111 -> grant sequence 0,1,2,3,0,... with one grant per cycle and resp_data matching each register in order.
- Backpressure: requester 2 granted on addr 14, then resp_ready[2]=0 for 3 cycles while requesters 0,1 are valid -> resp_valid=0100 and resp_data stable for 3 cycles, req_ready=0000; requester 3's grant follows the cycle resp_ready[2] rises.
- Zero register: req_addr[1]=31 with the regfile holding 0x10F at index 31 and ZERO_REG=1 -> resp_data=0. With ZERO_REG=0 -> resp_data=0x10F.
- Pointer wrap and idle hold: grant to requester 3, then only requester 0 valid -> requester 0 granted next. rd_sel holds the last value while idle.
- Reset mid-operation: reset asserted while state=BUSY with resp_ready=0 -> next cycle resp_valid=0, req_ready=0, rr_ptr=0; the first grant after reset goes to the lowest valid index.
